// File: rtl/antilog_q412_pipe.sv
// antilog_q412_pipe: three-stage log2 -> linear converter, Q4.12 in and out.
// Mantissa is a 65-entry 2^(i/64) table with 6-bit linear interpolation.
// It is scaled by the integer exponent with round-half-up, saturated to
// +/-0x7FFF, and the sign is applied last.
module antilog_q412_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_log,
  input  logic        in_sign,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_lin,
  output logic        out_sat
);

  // round(2^(i/64) * 32768), i = 0..64
  function automatic logic [16:0] exp2_rom(input logic [6:0] idx);
    logic [16:0] t;
    case (idx)
      7'd0:  t = 17'd32768; 7'd1:  t = 17'd33125; 7'd2:  t = 17'd33486; 7'd3:  t = 17'd33850;
      7'd4:  t = 17'd34219; 7'd5:  t = 17'd34591; 7'd6:  t = 17'd34968; 7'd7:  t = 17'd35349;
      7'd8:  t = 17'd35734; 7'd9:  t = 17'd36123; 7'd10: t = 17'd36516; 7'd11: t = 17'd36914;
      7'd12: t = 17'd37316; 7'd13: t = 17'd37722; 7'd14: t = 17'd38133; 7'd15: t = 17'd38548;
      7'd16: t = 17'd38968; 7'd17: t = 17'd39392; 7'd18: t = 17'd39821; 7'd19: t = 17'd40255;
      7'd20: t = 17'd40693; 7'd21: t = 17'd41136; 7'd22: t = 17'd41584; 7'd23: t = 17'd42037;
      7'd24: t = 17'd42495; 7'd25: t = 17'd42958; 7'd26: t = 17'd43425; 7'd27: t = 17'd43898;
      7'd28: t = 17'd44376; 7'd29: t = 17'd44859; 7'd30: t = 17'd45348; 7'd31: t = 17'd45842;
      7'd32: t = 17'd46341; 7'd33: t = 17'd46846; 7'd34: t = 17'd47356; 7'd35: t = 17'd47871;
      7'd36: t = 17'd48393; 7'd37: t = 17'd48920; 7'd38: t = 17'd49452; 7'd39: t = 17'd49991;
      7'd40: t = 17'd50535; 7'd41: t = 17'd51085; 7'd42: t = 17'd51642; 7'd43: t = 17'd52204;
      7'd44: t = 17'd52773; 7'd45: t = 17'd53347; 7'd46: t = 17'd53928; 7'd47: t = 17'd54515;
      7'd48: t = 17'd55109; 7'd49: t = 17'd55709; 7'd50: t = 17'd56316; 7'd51: t = 17'd56929;
      7'd52: t = 17'd57549; 7'd53: t = 17'd58176; 7'd54: t = 17'd58809; 7'd55: t = 17'd59449;
      7'd56: t = 17'd60097; 7'd57: t = 17'd60751; 7'd58: t = 17'd61413; 7'd59: t = 17'd62081;
      7'd60: t = 17'd62757; 7'd61: t = 17'd63441; 7'd62: t = 17'd64132; 7'd63: t = 17'd64830;
      7'd64: t = 17'd65536;
      default: t = 17'd0;
    endcase
    return t;
  endfunction

  // Returns {sat, mag[14:0]}: mantissa scaled by 2^(n-3) with round half up.
  function automatic logic [15:0] scale_round_sat(input logic [15:0] m,
                                                  input logic signed [3:0] n);
    logic signed [4:0] s;
    logic [16:0] sum;
    logic [16:0] mag;
    logic [15:0] res;
    s = 5'sd3 - $signed({n[3], n});
    if (n > 4'sd2) begin
      res = {1'b1, 15'h7FFF};
    end else begin
      sum = {1'b0, m} + (17'd1 << (s - 5'sd1));
      mag = sum >> s;
      if (mag[16:15] != 2'b00) res = {1'b1, 15'h7FFF};
      else                     res = {1'b0, mag[14:0]};
    end
    return res;
  endfunction

  logic        en;
  logic        vld_p0_q, vld_p1_q, vld_p2_q;
  logic [15:0] t_lo_p0_q;
  logic [10:0] diff_p0_q;
  logic [5:0]  f_p0_q;
  logic signed [3:0] n_p0_q, n_p1_q;
  logic        sign_p0_q, sign_p1_q, zero_p0_q, zero_p1_q;
  logic [15:0] m_p1_q;
  logic [15:0] lin_p2_q;
  logic        sat_p2_q;

  logic [16:0] t_lo_d, t_hi_d;
  logic [16:0] prod_d;
  logic [15:0] m_d;
  logic [15:0] scaled_d;
  logic [15:0] mag_d;

  // The whole pipe advances only when the output slot is free or being drained.
  assign en        = out_ready | ~vld_p2_q;
  assign in_ready  = en;
  assign out_valid = vld_p2_q;
  assign out_lin   = lin_p2_q;
  assign out_sat   = sat_p2_q;

  // Table lookups for the bracketing entries of the index.
  always_comb begin
    t_lo_d = exp2_rom({1'b0, in_log[11:6]});
    t_hi_d = exp2_rom({1'b0, in_log[11:6]} + 7'd1);
  end

  // Interpolation and final scaling
  always_comb begin
    prod_d   = {6'd0, diff_p0_q} * {11'd0, f_p0_q};
    m_d      = t_lo_p0_q + 16'(prod_d >> 6);
    scaled_d = scale_round_sat(m_p1_q, n_p1_q);
    mag_d    = {1'b0, scaled_d[14:0]};
  end

  // Stage valids; cleared by reset so in-flight samples are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (en) begin
      vld_p0_q <= in_valid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  // ---- S1: register fields and table entries
  always_ff @(posedge clk) begin
    if (en) begin
      t_lo_p0_q <= 16'(t_lo_d);
      diff_p0_q <= 11'(t_hi_d - t_lo_d);
      f_p0_q    <= in_log[5:0];
      n_p0_q    <= $signed(in_log[15:12]);
      sign_p0_q <= in_sign;
      zero_p0_q <= in_zero;
    end
  end

  // ---- S2: interpolated mantissa
  always_ff @(posedge clk) begin
    if (en) begin
      m_p1_q    <= m_d;
      n_p1_q    <= n_p0_q;
      sign_p1_q <= sign_p0_q;
      zero_p1_q <= zero_p0_q;
    end
  end

  // ---- S3: round, saturate, sign; output registers clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lin_p2_q <= 16'h0000;
      sat_p2_q <= 1'b0;
    end else if (en) begin
      if (zero_p1_q) begin
        lin_p2_q <= 16'h0000;
        sat_p2_q <= 1'b0;
      end else begin
        lin_p2_q <= sign_p1_q ? (~mag_d + 16'd1) : mag_d;
        sat_p2_q <= scaled_d[15];
      end
    end
  end

endmodule

// File: tb/tb_antilog_q412_pipe.sv
// Bench for antilog_q412_pipe: reference model from the integer rules with a
// real-arithmetic exp2 table, scoreboard queue, and a negedge monitor.
module tb_antilog_q412_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_zero;
  logic [15:0] in_log;
  logic        out_valid, out_ready, out_sat;
  logic [15:0] out_lin;

  always #5 clk = ~clk;

  antilog_q412_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_log(in_log), .in_sign(in_sign), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lin(out_lin), .out_sat(out_sat)
  );

  typedef struct {
    logic [15:0] lin;
    logic        sat;
    int          cyc;
    bit          chk_lat;
    bit          sweep;
    logic [15:0] code;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   tab[0:64];
  int   mono_viol = 0;
  bit   first_sweep = 1'b1;
  logic signed [15:0] prev_sweep;
  bit   hold_vld = 1'b0;
  logic [15:0] hold_lin;
  logic hold_sat;
  bit   bp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: 2^(n + (k + f/64)/64) rules with plain integer arithmetic.
  task automatic model(input logic [15:0] lg, input bit sg, input bit zr,
                       output logic [15:0] lin, output logic sat);
    int n, k, f, m, s, mag;
    if (zr) begin
      lin = 16'h0000; sat = 1'b0;
      return;
    end
    n = int'($signed(lg[15:12]));
    k = int'(lg[11:6]);
    f = int'(lg[5:0]);
    m = tab[k] + ((tab[k+1] - tab[k]) * f) / 64;
    sat = 1'b0;
    if (n >= 3) begin
      mag = 32767; sat = 1'b1;
    end else begin
      s = 3 - n;
      mag = (m + (1 << (s - 1))) >> s;
      if (mag >= 32768) begin mag = 32767; sat = 1'b1; end
    end
    lin = sg ? 16'(-mag) : 16'(mag);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [15:0] lg, input bit sg, input bit zr,
                      input bit lat, input bit sw);
    exp_t e;
    int   w;
    bit   acc;
    w = 0; acc = 1'b0;
    model(lg, sg, zr, e.lin, e.sat);
    e.chk_lat = lat; e.sweep = sw; e.code = lg; e.cyc = 0;
    in_log = lg; in_sign = sg; in_zero = zr; in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        e.cyc = cyc;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      w++;
      if (!acc && w > 1000) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=stalled required=accepted code=%h", lg);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Monitor: pops on every transfer, checks hold-stability under stall.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld && out_valid) begin
        check("stall_lin", out_lin, hold_lin);
        check("stall_sat", out_sat, hold_sat);
      end
      hold_vld = out_valid && !out_ready;
      hold_lin = out_lin;
      hold_sat = out_sat;
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output actual=%h required=none", out_lin);
        end else begin
          e = sbq.pop_front();
          if (out_lin !== e.lin)
            $display("FAIL lin code=%h actual=%h required=%h", e.code, out_lin, e.lin);
          checks++;
          if (out_lin !== e.lin) errors++;
          check("sat", 32'(out_sat), 32'(e.sat));
          if (e.chk_lat) check("latency", cyc - e.cyc, 3);
          if (e.sweep) begin
            if (!first_sweep && $signed(out_lin) < prev_sweep) mono_viol++;
            prev_sweep  = $signed(out_lin);
            first_sweep = 1'b0;
          end
        end
      end
    end
  end

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 200) begin tick(1); w++; end
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i <= 64; i++)
      tab[i] = $rtoi((2.0 ** (real'(i) / 64.0)) * 32768.0 + 0.5);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_log = 16'h0; in_sign = 1'b0; in_zero = 1'b0;
    tick(3);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_lin", 32'(out_lin), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;

    // Directed conversions
    send(16'h0000, 0, 0, 1, 0);
    send(16'hF000, 0, 0, 1, 0);
    send(16'hF800, 0, 0, 1, 0);
    send(16'h8000, 0, 0, 1, 0);
    send(16'h1000, 1, 0, 1, 0);
    send(16'h7FFF, 1, 1, 1, 0);
    send(16'h3000, 0, 0, 1, 0);
    send(16'h3000, 1, 0, 1, 0);
    send(16'h2FFF, 0, 0, 1, 0);
    send(16'h7FFF, 0, 0, 1, 0);
    drain();

    // Random conversions with input bubbles
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) tick(1);
      send(16'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1, 0);
    end
    drain();

    // Backpressure with random out_ready
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          if ($urandom_range(0, 4) == 0) tick(1);
          send(16'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 0, 0);
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with three samples in flight
    send(16'h0400, 0, 0, 0, 0);
    send(16'h0800, 1, 0, 0, 0);
    send(16'h0C00, 0, 0, 0, 0);
    rst = 1'b1; out_ready = 1'b0;
    tick(1);
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_lin", 32'(out_lin), 0);
    check("midrst_out_sat", 32'(out_sat), 0);
    sbq.delete();
    rst = 1'b0; out_ready = 1'b1;
    tick(6);
    send(16'h0000, 1, 0, 1, 0);
    drain();

    // Full sweep in signed order, back to back
    for (int i = 0; i < 65536; i++)
      send(16'(i) ^ 16'h8000, 0, 0, 1, 1);
    drain();
    check("sweep_monotonic_violations", mono_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
